sc_config_master: RTL
=====================

# sc_config_master

Avalon-MM initiator that commits a complete scan-converter configuration set into the `sc_config_top` register slave as one atomic burst of single-word writes. It optionally polls the status register until a masked bit is set, such as a vblank flag, before writing. The block sits between the mode-switch control logic and the config slave's Avalon port, so that a full register set lands in a bounded, known window.

## Interface
Parameters:
- `TIMEOUT`, default 65535: the maximum number of poll cycles before the block aborts. Must be ≥1.

Ports:
- `clk_i` — in, 1: the single clock.
- `rst_i` — in, 1: asynchronous, active-high reset.
- `start_i` — in, 1: one-cycle request to commit the config set.
- `cfg_h_i`, `cfg_h2_i`, `cfg_v_i`, `cfg_misc_i`, `cfg_sl_i`, `cfg_sl2_i` — in, 32 each: the config words to write.
- `poll_mask_i` — in, 32: the status bits to wait for. A value of 0 skips polling.
- `busy_o` — out, 1: high from the cycle after `start_i` is accepted until the cycle of `done_o`.
- `done_o` — out, 1: one-cycle pulse when a sequence ends, whether it completed or aborted.
- `timeout_o` — out, 1: sticky flag marking the last sequence as aborted by poll timeout.
- `status_o` — out, 32: the last SC_STATUS word read.
- `avalon_m_address` — out, 4: the register number.
- `avalon_m_writedata` — out, 32: the write data.
- `avalon_m_readdata` — in, 32: the read data. It is valid in any cycle where `read` is asserted and `waitrequest_n` is high.
- `avalon_m_byteenable` — out, 4: always 4'hF during a transfer, 0 otherwise.
- `avalon_m_write` — out, 1: write strobe.
- `avalon_m_read` — out, 1: read strobe.
- `avalon_m_chipselect` — out, 1: high whenever `read` or `write` is high.
- `avalon_m_waitrequest_n` — in, 1: the slave accepts the current transfer at a rising edge where this input is high.

## Operation
- Register numbers:
  - 0: SC_STATUS
  - 3: H_CONFIG
  - 4: H_CONFIG2
  - 5: V_CONFIG
  - 6: MISC_CONFIG
  - 7: SL_CONFIG
  - 8: SL_CONFIG2
- FSM states are IDLE, POLL, WRITE and FINISH.
- **IDLE:**
  - When `start_i` is high, latch all six cfg words and `poll_mask_i` into shadow registers and clear `timeout_o`.
  - Go to POLL if the shadowed mask is nonzero and polling is compiled in; otherwise go to WRITE with index 0.
  - Stay in IDLE when `start_i` is low.
- **POLL:**
  - Assert `read` and `chipselect` with address 0, held stable until accepted.
  - On acceptance, load `status_o` from readdata.
  - If `(readdata & mask) != 0`, go to WRITE with index 0. Otherwise issue another read back-to-back.
  - A 17-bit counter, cleared on entry, increments every cycle spent in POLL.
  - When the counter reaches `TIMEOUT` without a match, set `timeout_o` and go to FINISH; no writes are issued.
  - A match in the same cycle the counter reaches `TIMEOUT` counts as a match.
- **WRITE:**
  - Drive address 3+index, the shadow word for that index, and `write`/`chipselect`, all held stable until accepted.
  - On acceptance, increment the index. After index 5 is accepted, go to FINISH.
- **FINISH:** pulse `done_o` for one cycle, deassert `busy_o`, then return to IDLE.
- `start_i` while busy or in FINISH is ignored; no queueing.
- Input cfg changes after start do not affect the sequence in flight.
- `read` and `write` are never asserted together. Bus outputs are 0 whenever no transfer is pending.

## Timing
- All outputs are 0 on reset: `busy_o`, `done_o`, `timeout_o`, `status_o`, and every bus output.
- Reset mid-sequence aborts immediately, with no `done_o` pulse. Registers already written stay written.
- Start is sampled at edge E. The first transfer (poll read or write) is driven in the cycle after E, and `busy_o` rises in that same cycle.
- With `waitrequest_n` held at 1 and no poll:
  - writes to 3..8 occupy cycles E+1 to E+6;
  - `done_o` pulses in cycle E+7;
  - `busy_o` is high from E+1 to E+6.
- Each cycle of `waitrequest_n`=0 extends the current transfer by one cycle.
- A matching poll read adds exactly one cycle before the first write.

## Configuration
- `SC_CFG_POLL_EN` defined: POLL state, timeout counter, `status_o` and `timeout_o` are implemented as described.
- `SC_CFG_POLL_EN` undefined:
  - POLL logic is absent and `poll_mask_i` is ignored;
  - `status_o` and `timeout_o` are tied to 0;
  - the sequence always begins with writes.
- Ports are identical in both builds.

## Structure
- Shared package `sc_config_pkg` holds the register-number constants (0–8) and the FSM state enum. `sc_config_top` uses the same constants.
- Single flat module with no sub-module. A transfer engine is too small to justify its own file.

## Test plan
- Reset, then start with cfgs 0x11111111..0x66666666, mask 0, `waitrequest_n`=1 → addresses 3,4,5,6,7,8 with matching data in E+1..E+6; `done_o` at E+7; `timeout_o`=0.
- Same sequence with `waitrequest_n` low 2 cycles on the address-5 write → that write held 3 cycles with stable address and data; `done_o` at E+9.
- Mask 0x1; status reads 0,0,1 → three reads at address 0; `status_o`=1; writes start the cycle after the third read.
- Mask 0x1, status always 0, `TIMEOUT`=8 → exactly 8 read cycles, no writes, `timeout_o`=1, `done_o` pulse. The next start clears `timeout_o`.
- `start_i` re-pulsed during writes, then `rst_i` asserted at the address-6 write → second start ignored; all outputs 0 immediately on reset; no `done_o` pulse.
- Build without `SC_CFG_POLL_EN`, mask 0xFFFFFFFF → no reads issued, writes begin at E+1, `status_o`=0.

Source files
------------

// File: rtl/sc_config_pkg.sv
// Shared register map and FSM encoding for the scan-converter config master and slave.
package sc_config_pkg;

  localparam logic [3:0] REG_SC_STATUS   = 4'd0;
  localparam logic [3:0] REG_H_CONFIG    = 4'd3;
  localparam logic [3:0] REG_H_CONFIG2   = 4'd4;
  localparam logic [3:0] REG_V_CONFIG    = 4'd5;
  localparam logic [3:0] REG_MISC_CONFIG = 4'd6;
  localparam logic [3:0] REG_SL_CONFIG   = 4'd7;
  localparam logic [3:0] REG_SL_CONFIG2  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POLL,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // Write order of the config set; index 5 is always the last word.
  function automatic logic [3:0] cfg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG_H_CONFIG;
      3'd1:    return REG_H_CONFIG2;
      3'd2:    return REG_V_CONFIG;
      3'd3:    return REG_MISC_CONFIG;
      3'd4:    return REG_SL_CONFIG;
      default: return REG_SL_CONFIG2;
    endcase
  endfunction

endpackage

// File: rtl/sc_config_master.sv
// Avalon-MM initiator committing six config words as one burst, optionally after polling SC_STATUS.
// Polling is built only when SC_CFG_POLL_EN is defined; otherwise status_o/timeout_o read 0.
module sc_config_master
  import sc_config_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] cfg_h_i,
  input  logic [31:0] cfg_h2_i,
  input  logic [31:0] cfg_v_i,
  input  logic [31:0] cfg_misc_i,
  input  logic [31:0] cfg_sl_i,
  input  logic [31:0] cfg_sl2_i,
  input  logic [31:0] poll_mask_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] status_o,
  output logic [3:0]  avalon_m_address,
  output logic [31:0] avalon_m_writedata,
  input  logic [31:0] avalon_m_readdata,
  output logic [3:0]  avalon_m_byteenable,
  output logic        avalon_m_write,
  output logic        avalon_m_read,
  output logic        avalon_m_chipselect,
  input  logic        avalon_m_waitrequest_n
);

  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [5:0][31:0]  shadow;
  logic [2:0]        idx;
  logic [31:0]       wdata;
  logic              accept;

  assign accept = avalon_m_waitrequest_n;

  always_comb begin
    case (idx)
      3'd0:    wdata = shadow[0];
      3'd1:    wdata = shadow[1];
      3'd2:    wdata = shadow[2];
      3'd3:    wdata = shadow[3];
      3'd4:    wdata = shadow[4];
      default: wdata = shadow[5];
    endcase
  end

`ifdef SC_CFG_POLL_EN
  logic [31:0] mask;
  logic [16:0] poll_cnt;
  logic        poll_hit;

  assign poll_hit = accept && ((avalon_m_readdata & mask) != '0);
`else
  logic unused_ok;
  assign unused_ok = ^{poll_mask_i, avalon_m_readdata, TIMEOUT_LAST};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    busy_o              = 1'b0;
    done_o              = 1'b0;
    avalon_m_address    = '0;
    avalon_m_writedata  = '0;
    avalon_m_byteenable = '0;
    avalon_m_write      = 1'b0;
    avalon_m_read       = 1'b0;
    avalon_m_chipselect = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
`ifdef SC_CFG_POLL_EN
          state_nxt = (poll_mask_i != '0) ? ST_POLL : ST_WRITE;
`else
          state_nxt = ST_WRITE;
`endif
        end
      end
`ifdef SC_CFG_POLL_EN
      ST_POLL: begin
        busy_o              = 1'b1;
        avalon_m_address    = REG_SC_STATUS;
        avalon_m_byteenable = 4'hF;
        avalon_m_read       = 1'b1;
        avalon_m_chipselect = 1'b1;
        // A hit on the final counted cycle still wins over the timeout.
        if (poll_hit) begin
          state_nxt = ST_WRITE;
        end else if (poll_cnt == TIMEOUT_LAST) begin
          state_nxt = ST_FINISH;
        end
      end
`endif
      ST_WRITE: begin
        busy_o              = 1'b1;
        avalon_m_address    = cfg_addr(idx);
        avalon_m_writedata  = wdata;
        avalon_m_byteenable = 4'hF;
        avalon_m_write      = 1'b1;
        avalon_m_chipselect = 1'b1;
        if (accept && cfg_addr(idx) == REG_SL_CONFIG2) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow <= '0;
      idx    <= '0;
    end else if (state == ST_IDLE && start_i) begin
      shadow <= {cfg_sl2_i, cfg_sl_i, cfg_misc_i, cfg_v_i, cfg_h2_i, cfg_h_i};
      idx    <= '0;
    end else if (state == ST_WRITE && accept) begin
      idx <= idx + 3'd1;
    end
  end

`ifdef SC_CFG_POLL_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask      <= '0;
      poll_cnt  <= '0;
      status_o  <= '0;
      timeout_o <= 1'b0;
    end else if (state == ST_IDLE && start_i) begin
      mask      <= poll_mask_i;
      poll_cnt  <= '0;
      timeout_o <= 1'b0;
    end else if (state == ST_POLL) begin
      poll_cnt <= poll_cnt + 17'd1;
      if (accept) begin
        status_o <= avalon_m_readdata;
      end
      if (state_nxt == ST_FINISH) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  assign status_o  = '0;
  assign timeout_o = 1'b0;
`endif

endmodule
